// File: rtl/prt_dp_pm_ldr.sv
// prt_dp_pm_ldr: loads a host image into the policy-maker ROM, verifies its checksum,
// and holds the policy-maker CPU in reset until a load completes cleanly.
module prt_dp_pm_ldr #(
    parameter int P_ADR = 10
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    input  logic             CFG_STR_IN,
    input  logic [P_ADR:0]   CFG_LEN_IN,
    input  logic [31:0]      CFG_SUM_IN,
    input  logic             ABORT_IN,
    input  logic [31:0]      HOST_DAT_IN,
    input  logic             HOST_VLD_IN,
    output logic             HOST_RDY_OUT,
    output logic             INIT_STR_OUT,
    output logic [31:0]      INIT_DAT_OUT,
    output logic             INIT_VLD_OUT,
    output logic             PM_RST_OUT,
    output logic             STA_BUSY_OUT,
    output logic             STA_DONE_OUT,
    output logic             STA_ERR_OUT,
    output logic [P_ADR:0]   STA_CNT_OUT
);
    localparam logic [2:0] IDLE = 3'd0, CLR = 3'd1, LOAD = 3'd2, CHK = 3'd3, DONE = 3'd4, ERR = 3'd5;
    localparam logic [P_ADR:0] LEN_MAX = {1'b1, {P_ADR{1'b0}}};
    localparam logic [P_ADR:0] ONE = {{P_ADR{1'b0}}, 1'b1};
    logic [2:0]     state, nxt;
    logic [P_ADR:0] len;
    logic [31:0]    sum, sum_exp;
    logic           hs, start, len_ok, last;
    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        hs     = HOST_VLD_IN && (state == LOAD);
        start  = CFG_STR_IN && (state == IDLE || state == DONE || state == ERR);
        len_ok = (CFG_LEN_IN != '0) && (CFG_LEN_IN <= LEN_MAX);
        last   = (STA_CNT_OUT + ONE) == len;
        nxt    = state;
        case (state)
            IDLE, DONE, ERR: nxt = start ? (len_ok ? CLR : ERR) : state;
            CLR:             nxt = ABORT_IN ? ERR : LOAD;
            LOAD:            nxt = ABORT_IN ? ERR : (hs && last) ? CHK : LOAD;
            CHK:             nxt = (sum == sum_exp) ? DONE : ERR;
            default:         nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            state        <= IDLE;
            len          <= '0;
            sum          <= '0;
            sum_exp      <= '0;
            HOST_RDY_OUT <= 1'b0;
            INIT_STR_OUT <= 1'b0;
            INIT_DAT_OUT <= '0;
            INIT_VLD_OUT <= 1'b0;
            PM_RST_OUT   <= 1'b1;
            STA_BUSY_OUT <= 1'b0;
            STA_DONE_OUT <= 1'b0;
            STA_ERR_OUT  <= 1'b0;
            STA_CNT_OUT  <= '0;
        end else begin
            state        <= nxt;
            HOST_RDY_OUT <= nxt == LOAD;
            INIT_STR_OUT <= nxt == CLR;
            INIT_VLD_OUT <= hs;
            PM_RST_OUT   <= nxt != DONE;
            STA_BUSY_OUT <= nxt == CLR || nxt == LOAD || nxt == CHK;
            STA_DONE_OUT <= nxt == DONE;
            STA_ERR_OUT  <= nxt == ERR;
            if (hs) INIT_DAT_OUT <= HOST_DAT_IN;
            if (start) begin
                len     <= CFG_LEN_IN;
                sum_exp <= CFG_SUM_IN;
            end
            if (nxt == CLR) begin
                STA_CNT_OUT <= '0;
                sum         <= '0;
            end else if (hs) begin
                STA_CNT_OUT <= STA_CNT_OUT + ONE;
                sum         <= sum + HOST_DAT_IN;
            end
        end
    end
endmodule

// File: tb/tb_prt_dp_pm_ldr.sv
// tb_prt_dp_pm_ldr: directed loads with a write scoreboard checked by a negedge monitor.
module tb_prt_dp_pm_ldr;
    logic        CLK_IN = 1'b0;
    logic        RST_IN = 1'b0;
    logic        CFG_STR_IN = 1'b0;
    logic [4:0]  CFG_LEN_IN = '0;
    logic [31:0] CFG_SUM_IN = '0;
    logic        ABORT_IN = 1'b0;
    logic [31:0] HOST_DAT_IN = '0;
    logic        HOST_VLD_IN = 1'b0;
    logic        HOST_RDY_OUT, INIT_STR_OUT, INIT_VLD_OUT, PM_RST_OUT;
    logic        STA_BUSY_OUT, STA_DONE_OUT, STA_ERR_OUT;
    logic [31:0] INIT_DAT_OUT;
    logic [4:0]  STA_CNT_OUT;
    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic        prev_hs = 1'b0;

    prt_dp_pm_ldr #(.P_ADR(4)) dut (
        .CLK_IN(CLK_IN), .RST_IN(RST_IN), .CFG_STR_IN(CFG_STR_IN), .CFG_LEN_IN(CFG_LEN_IN),
        .CFG_SUM_IN(CFG_SUM_IN), .ABORT_IN(ABORT_IN), .HOST_DAT_IN(HOST_DAT_IN),
        .HOST_VLD_IN(HOST_VLD_IN), .HOST_RDY_OUT(HOST_RDY_OUT), .INIT_STR_OUT(INIT_STR_OUT),
        .INIT_DAT_OUT(INIT_DAT_OUT), .INIT_VLD_OUT(INIT_VLD_OUT), .PM_RST_OUT(PM_RST_OUT),
        .STA_BUSY_OUT(STA_BUSY_OUT), .STA_DONE_OUT(STA_DONE_OUT), .STA_ERR_OUT(STA_ERR_OUT),
        .STA_CNT_OUT(STA_CNT_OUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ROM strobe must match the next scoreboard entry and trail its handshake by one cycle.
    always @(negedge CLK_IN) begin
        if (INIT_STR_OUT === 1'b1 || INIT_VLD_OUT === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: str=%b vld=%b dat=%h, expected no write (t=%0t)",
                         INIT_STR_OUT, INIT_VLD_OUT, INIT_DAT_OUT, $time);
            end else begin
                chk("init_write", {31'd0, INIT_STR_OUT, INIT_STR_OUT ? 32'h0 : INIT_DAT_OUT},
                    {31'd0, exp_q.pop_front()});
            end
        end
        if (prev_hs || INIT_VLD_OUT === 1'b1) chk("vld_latency", {63'd0, INIT_VLD_OUT}, {63'd0, prev_hs});
        prev_hs = HOST_VLD_IN && (HOST_RDY_OUT === 1'b1) && RST_IN;
    end

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic start(input logic [4:0] len, input logic [31:0] sum, input bit valid);
        CFG_STR_IN = 1'b1;
        CFG_LEN_IN = len;
        CFG_SUM_IN = sum;
        if (valid) exp_q.push_back({1'b1, 32'h0});
        tick();
        CFG_STR_IN = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] dat, input bit abort);
        bit ok;
        int n;
        HOST_VLD_IN = 1'b1;
        HOST_DAT_IN = dat;
        ABORT_IN    = abort;
        n = 0;
        do begin
            ok = HOST_RDY_OUT;
            tick();
            n++;
        end while (!ok && n < 200);
        ABORT_IN = 1'b0;
        if (ok) exp_q.push_back({1'b0, dat});
        else chk("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        HOST_VLD_IN = 1'b0;
        n = 0;
        while (STA_BUSY_OUT && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("busy_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic chk_status(input string name, input bit done, input bit err, input logic [4:0] cnt);
        chk({name, "_done"}, {63'd0, STA_DONE_OUT}, {63'd0, done});
        chk({name, "_err"}, {63'd0, STA_ERR_OUT}, {63'd0, err});
        chk({name, "_pm_rst"}, {63'd0, PM_RST_OUT}, {63'd0, !done});
        chk({name, "_cnt"}, {59'd0, STA_CNT_OUT}, {59'd0, cnt});
        chk({name, "_rdy"}, {63'd0, HOST_RDY_OUT}, 64'd0);
        chk({name, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_rdy", {63'd0, HOST_RDY_OUT}, 64'd0);
        chk("rst_str", {63'd0, INIT_STR_OUT}, 64'd0);
        chk("rst_vld", {63'd0, INIT_VLD_OUT}, 64'd0);
        chk("rst_dat", {32'd0, INIT_DAT_OUT}, 64'd0);
        chk("rst_pm_rst", {63'd0, PM_RST_OUT}, 64'd1);
        chk("rst_sta", {59'd0, STA_BUSY_OUT, STA_DONE_OUT, STA_ERR_OUT, 2'b00}, 64'd0);
        chk("rst_cnt", {59'd0, STA_CNT_OUT}, 64'd0);
        RST_IN = 1'b1;
        tick();

        // Nominal full-rate load
        start(5'd4, 32'h0000000A, 1'b1);
        chk("clr_busy", {63'd0, STA_BUSY_OUT}, 64'd1);
        chk("clr_pm_rst", {63'd0, PM_RST_OUT}, 64'd1);
        chk("clr_rdy", {63'd0, HOST_RDY_OUT}, 64'd0);
        for (int i = 1; i <= 4; i++) send_word(32'(i), 1'b0);
        wait_idle();
        chk_status("nominal", 1'b1, 1'b0, 5'd4);

        // Stalling host, sum wraps
        start(5'd16, 32'hFFFFFFF0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send_word(32'hFFFFFFFF, 1'b0);
            HOST_VLD_IN = 1'b0;
            tick();
        end
        wait_idle();
        chk_status("wrap", 1'b1, 1'b0, 5'd16);

        // Checksum mismatch then recovery
        start(5'd2, 32'd5, 1'b1);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        wait_idle();
        chk_status("mismatch", 1'b0, 1'b1, 5'd2);
        start(5'd2, 32'd3, 1'b1);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        wait_idle();
        chk_status("recover", 1'b1, 1'b0, 5'd2);

        // Bad lengths go straight to ERR
        start(5'd0, 32'd0, 1'b0);
        chk_status("len0", 1'b0, 1'b1, 5'd2);
        tick();
        chk("len0_rdy_late", {63'd0, HOST_RDY_OUT}, 64'd0);
        start(5'd17, 32'd0, 1'b0);
        chk_status("len17", 1'b0, 1'b1, 5'd2);
        tick();
        chk("len17_busy", {63'd0, STA_BUSY_OUT}, 64'd0);

        // Abort with coincident handshake; restart request in LOAD is ignored
        start(5'd8, 32'd36, 1'b1);
        send_word(32'h11, 1'b0);
        HOST_VLD_IN = 1'b0;
        CFG_STR_IN = 1'b1;
        CFG_LEN_IN = 5'd2;
        tick();
        CFG_STR_IN = 1'b0;
        tick();
        chk("load_str_ignored_rdy", {63'd0, HOST_RDY_OUT}, 64'd1);
        chk("load_str_ignored_cnt", {59'd0, STA_CNT_OUT}, 64'd1);
        send_word(32'h22, 1'b0);
        send_word(32'h33, 1'b1);
        HOST_VLD_IN = 1'b0;
        chk("abort_err", {63'd0, STA_ERR_OUT}, 64'd1);
        tick();
        tick();
        chk_status("abort", 1'b0, 1'b1, 5'd3);

        // Reset mid-load with a handshake pending
        start(5'd8, 32'd36, 1'b1);
        for (int i = 1; i <= 5; i++) send_word(32'(i), 1'b0);
        RST_IN = 1'b0;
        tick();
        chk("mid_rst_rdy", {63'd0, HOST_RDY_OUT}, 64'd0);
        chk("mid_rst_vld", {63'd0, INIT_VLD_OUT}, 64'd0);
        chk("mid_rst_dat", {32'd0, INIT_DAT_OUT}, 64'd0);
        chk("mid_rst_pm_rst", {63'd0, PM_RST_OUT}, 64'd1);
        chk("mid_rst_sta", {61'd0, STA_BUSY_OUT, STA_DONE_OUT, STA_ERR_OUT}, 64'd0);
        chk("mid_rst_cnt", {59'd0, STA_CNT_OUT}, 64'd0);
        tick();
        RST_IN = 1'b1;
        repeat (4) tick();
        HOST_VLD_IN = 1'b0;
        chk("post_rst_rdy", {63'd0, HOST_RDY_OUT}, 64'd0);
        chk("post_rst_q_empty", 64'(exp_q.size()), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prt_dp_pm_ldr.md
PRT_DP_PM_LDR -- requirements
Module: prt_dp_pm_ldr

Interface
REQ-001 SHALL have parameter P_ADR, default 10: PM ROM address bits; ROM depth is 2**P_ADR words of 32 bits.
REQ-002 SHALL have port CLK_IN  in  1  single clock for all logic.
REQ-003 SHALL have port RST_IN  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port CFG_STR_IN  in  1  load-start pulse.
REQ-005 SHALL have port CFG_LEN_IN  in  P_ADR+1  number of words to load.
REQ-006 SHALL have port CFG_SUM_IN  in  32  expected checksum: sum of all words, mod 2**32.
REQ-007 SHALL have port ABORT_IN  in  1  abort the load in progress.
REQ-008 SHALL have port HOST_DAT_IN  in  32  host image word.
REQ-009 SHALL have port HOST_VLD_IN  in  1  host word valid.
REQ-010 SHALL have port HOST_RDY_OUT  out  1  loader ready; a word transfers when VLD and RDY are both high on a rising edge.
REQ-011 SHALL have port INIT_STR_OUT  out  1  ROM write-pointer clear pulse.
REQ-012 SHALL have port INIT_DAT_OUT  out  32  ROM write data.
REQ-013 SHALL have port INIT_VLD_OUT  out  1  ROM write strobe; the ROM write pointer post-increments on each strobe.
REQ-014 SHALL have port PM_RST_OUT  out  1  active-high reset hold for the policy maker CPU.
REQ-015 SHALL have port STA_BUSY_OUT  out  1  load in progress.
REQ-016 SHALL have port STA_DONE_OUT  out  1  last load completed with a checksum match.
REQ-017 SHALL have port STA_ERR_OUT  out  1  last load failed.
REQ-018 SHALL have port STA_CNT_OUT  out  P_ADR+1  number of words accepted in the current or last load.

Function
REQ-019 SHALL implement an FSM with states IDLE, CLR, LOAD, CHK, DONE and ERR.
REQ-020 IDLE/DONE/ERR: CFG_STR_IN=1 SHALL capture CFG_LEN_IN and CFG_SUM_IN; next state is CLR if 1 <= LEN <= 2**P_ADR, otherwise ERR.
REQ-021 On an out-of-range LEN, INIT_STR_OUT SHALL stay low.
REQ-022 CFG_STR_IN SHALL be ignored in CLR, LOAD and CHK.
REQ-023 CLR SHALL last exactly 1 cycle.
REQ-024 During CLR, INIT_STR_OUT=1, the word counter and running sum SHALL be cleared, and STA_DONE_OUT and STA_ERR_OUT SHALL be cleared.
REQ-025 After CLR the FSM SHALL go to LOAD.
REQ-026 HOST_RDY_OUT SHALL equal (state==LOAD) and SHALL be a registered output.
REQ-027 Each accepted word SHALL: increment the counter; add the word to the 32-bit running sum (carry discarded); drive INIT_DAT_OUT=word and INIT_VLD_OUT=1 in the following cycle.
REQ-028 INIT_VLD_OUT SHALL be a 1-cycle pulse per word, with 1-cycle latency from the handshake.
REQ-029 INIT_DAT_OUT SHALL hold its value when INIT_VLD_OUT=0.
REQ-030 Acceptance of word number LEN SHALL move the FSM to CHK, so HOST_RDY_OUT is low from the next cycle; no extra word SHALL ever be accepted.
REQ-031 HOST_VLD_IN low in LOAD SHALL stall the load indefinitely, with no timeout.
REQ-032 CHK SHALL last 1 cycle: running sum == captured SUM goes to DONE, otherwise to ERR.
REQ-033 ABORT_IN=1 in CLR or LOAD SHALL go to ERR next cycle; a handshake in that same cycle SHALL still be written.
REQ-034 ABORT_IN SHALL be ignored in all other states.
REQ-035 PM_RST_OUT SHALL be 1 in all states except DONE.
REQ-036 PM_RST_OUT SHALL fall on the cycle DONE is entered.
REQ-037 PM_RST_OUT SHALL rise on the same cycle CLR is entered.
REQ-038 STA_BUSY_OUT SHALL be 1 in CLR, LOAD and CHK.
REQ-039 STA_DONE_OUT SHALL be 1 in DONE; STA_ERR_OUT SHALL be 1 in ERR.
REQ-040 All outputs SHALL be registered.

Reset
REQ-041 RST_IN=0 at a rising edge SHALL force IDLE from any state, including mid-LOAD.
REQ-042 Under reset: HOST_RDY_OUT=0, INIT_STR_OUT=0, INIT_VLD_OUT=0, INIT_DAT_OUT=0, PM_RST_OUT=1, STA_*=0, counter=0, sum=0.
REQ-043 Under reset, no INIT_VLD_OUT pulse SHALL be issued for a handshake coincident with reset.

Verification (P_ADR=4)
REQ-044 Nominal load: LEN=4, SUM=0x0000000A, words 1,2,3,4 at full rate -> INIT_STR pulse, then 4 INIT_VLD pulses (DAT 1..4) each 1 cycle after its handshake; DONE, PM_RST_OUT=0, STA_CNT_OUT=4.
REQ-045 Stalling host and wrap: LEN=16, words 0xFFFFFFFF x16 with VLD toggling every other cycle, SUM=0xFFFFFFF0 -> 16 writes, sum wraps correctly, DONE.
REQ-046 Checksum mismatch and error recovery: LEN=2, SUM=5, words 1,2 -> ERR, STA_ERR_OUT=1, PM_RST_OUT=1; a new CFG_STR_IN with a correct SUM -> DONE.
REQ-047 Bad length: LEN=0 and LEN=17 -> ERR on the next cycle, no INIT_STR or INIT_VLD pulses, HOST_RDY_OUT never 1.
REQ-048 Abort with coincident handshake: LEN=8, ABORT_IN together with the 3rd handshake -> 3 writes, ERR, HOST_RDY_OUT=0; CFG_STR_IN asserted in LOAD -> ignored.
REQ-049 Reset mid-operation: RST_IN=0 after 5 of 8 words -> IDLE, all outputs at reset values, PM_RST_OUT=1, no further INIT_VLD pulses.
